dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single byte-wide data memory between two requesters. Port 0 is the core load/store path; port 1 is the debug/DMA path.
- Round-robin arbitration over a req/gnt/done handshake.
- Each granted 1/2/4/8-byte access is sequenced as one byte beat per clock, little-endian.
- Sits between the requesters and the data memory's clk/Mem_Read/Mem_Write/address/write_Data/read_Data interface.

Parameters:
- addr_size, 64, width of all byte addresses.
- data_length, 64, width of requester data buses; must be 64.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0 / req1  input  1  access request; held until the matching gnt.
- we0 / we1  input  1  1 = store, 0 = load.
- addr0 / addr1  input  addr_size  starting byte address.
- size0 / size1  input  2  0 = byte, 1 = half, 2 = word, 3 = double.
- uns0 / uns1  input  1  load zero-extend when 1, sign-extend when 0.
- wdata0 / wdata1  input  data_length  store data; low bytes used.
- gnt0 / gnt1  output  1  one-cycle pulse: command accepted.
- done0 / done1  output  1  one-cycle pulse: access complete.
- rdata0 / rdata1  output  data_length  extended load result; valid from done, held until that port's next load done.
- mem_read  output  1  to Mem_Read.
- mem_write  output  1  to Mem_Write.
- mem_addr  output  addr_size  to address.
- mem_wdata  output  8  to write_Data (low byte).
- mem_rdata  input  8  from read_Data (low byte).

Behaviour:
- Reset (async, immediate):
  - State=IDLE, beat=0, last-granted pointer=1 (port 0 wins the first tie).
  - All outputs 0, including rdata0/1 and all mem_* outputs.
  - Reset mid-access aborts it with no done. Bytes already written stay written. mem_write drops asynchronously.
- All outputs are registered. The memory writes level-sensitively, so mem_addr, mem_wdata and mem_write must change only at clock edges and never glitch.
- States: IDLE, XFER, DONE.
- IDLE:
  - Samples req0/req1 each edge.
  - One requester: select it. Both: select the port not last granted, then update the pointer.
  - At that edge, latch we, addr, size, uns and wdata from the selected port. Move to XFER with beat=0 and pulse that port's gnt for the first XFER cycle.
  - No req: stay in IDLE, mem_read=mem_write=0.
- XFER, cycle k (k = 0..N-1, N = 1 << size):
  - mem_addr = latched addr + k, modulo 2^addr_size.
  - Store: mem_write=1, mem_wdata = wdata[8k+7:8k].
  - Load: mem_read=1; mem_rdata is captured into result byte k at the end of the cycle.
  - Misaligned addresses are legal and are not split or flagged.
  - After beat N-1, go to DONE.
- DONE (1 cycle):
  - mem_read=mem_write=0.
  - Owning port's done=1.
  - For loads, rdata = result extended from bit 8N-1: zero-extend if uns=1, sign-extend if uns=0. Size 3 is unchanged.
  - Stores leave rdata unchanged.
  - Next state is IDLE.
- Latency: req sampled at edge E gives gnt in cycle E+1, N beat cycles, done in cycle E+N+1.
- Back-to-back requests: the next grant is decided at the end of the IDLE cycle that follows DONE. Minimum period is N+2 cycles.
- req is ignored outside IDLE. A requester may keep req high after gnt only to present a new command, which is taken at the next IDLE.
- Changing a port's inputs while it is being serviced has no effect, because the command is latched.
- Both ports requesting continuously alternate strictly 0,1,0,1…
- Never both gnt, never both done, never mem_read and mem_write together.

Test Plan:
- Preload byte 12=0xAA and all other bytes 0xFF. Port 0 loads addr=12, size=0, uns=0 -> gnt0 1 cycle after sample, 1 beat at mem_addr 12, done0 in cycle 2, rdata0=0xFFFF_FFFF_FFFF_FFAA. Repeat with uns=1 -> rdata0=0x0000_0000_0000_00AA.
- Port 1 stores addr=40, size=3, wdata=0x0807_0605_0403_0201 -> 8 beats, mem_addr 40..47, mem_wdata 01..08. done1 at cycle 9. Then a double load at 40 returns 0x0807_0605_0403_0201.
- req0 and req1 asserted together from reset, held for 4 transactions -> grants in order 0,1,0,1, with no gnt/done overlap.
- Port 0 half store at addr=0xFFFF_FFFF_FFFF_FFFF with wdata=0x1234 -> beats at 0xFF…FF (0x34) then 0x0 (0x12). Address wraps.
- Assert reset during beat 3 of an 8-byte store -> outputs 0 immediately, no done1. Bytes 0..2 are written and bytes 3..7 are untouched. The next req0 is granted normally.
- Word load at addr=5 of 0x80_00_00_00 (LE bytes 00,00,00,80), uns=0 -> rdata=0xFFFF_FFFF_8000_0000.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter_if
// Bundles the two requester handshakes and the byte-wide data-memory port
// that dmem_port_arbiter sits between.
//
//   Requester n (n = 0 core load/store, n = 1 debug/DMA):
//     reqn   request, held until gntn
//     wen    1 = store, 0 = load
//     addrn  starting byte address
//     sizen  0 byte, 1 half, 2 word, 3 double
//     unsn   load zero-extend (1) / sign-extend (0)
//     wdatan store data, low bytes used
//     gntn   one-cycle pulse, command accepted
//     donen  one-cycle pulse, access complete
//     rdatan extended load result, held until the next load done
//   Memory:
//     mem_read / mem_write / mem_addr / mem_wdata  towards the memory
//     mem_rdata                                    from the memory
//
// slave  : the arbiter's view.
// master : the requesters' and memory's view (used by the testbench).
// -----------------------------------------------------------------------------
interface dmem_port_arbiter_if #(
  parameter int addr_size   = 64,
  parameter int data_length = 64
);
  logic                   req0,   req1;
  logic                   we0,    we1;
  logic [addr_size-1:0]   addr0,  addr1;
  logic [1:0]             size0,  size1;
  logic                   uns0,   uns1;
  logic [data_length-1:0] wdata0, wdata1;
  logic                   gnt0,   gnt1;
  logic                   done0,  done1;
  logic [data_length-1:0] rdata0, rdata1;

  logic                   mem_read;
  logic                   mem_write;
  logic [addr_size-1:0]   mem_addr;
  logic [7:0]             mem_wdata;
  logic [7:0]             mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, size0, size1,
           uns0, uns1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, done0, done1, rdata0, rdata1,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, size0, size1,
           uns0, uns1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
// Shares one byte-wide data memory between two requesters with round-robin
// arbitration. A granted 1/2/4/8-byte access is played out as one byte beat
// per clock, little-endian, then a single DONE cycle reports completion and
// (for loads) presents the sign/zero-extended result.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; aborts any access in flight
//   bus    dmem_port_arbiter_if.slave (requester handshakes + memory port)
//
// Every output is a flop: the memory writes level-sensitively, so mem_addr,
// mem_wdata and mem_write must only move on clock edges. data_length must be
// 64.
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int addr_size   = 64,
  parameter int data_length = 64
) (
  input  logic               clk,
  input  logic               reset,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index of the final beat for a given access size (N-1).
  function automatic logic [2:0] last_beat(input logic [1:0] sz);
    logic [2:0] lb;
    case (sz)
      2'd0:    lb = 3'd0;
      2'd1:    lb = 3'd1;
      2'd2:    lb = 3'd3;
      default: lb = 3'd7;
    endcase
    return lb;
  endfunction

  // Extend the assembled load result from bit 8N-1.
  function automatic logic [data_length-1:0] extend(
    input logic [data_length-1:0] r,
    input logic [1:0]             sz,
    input logic                   u
  );
    logic [data_length-1:0] v;
    case (sz)
      2'd0:    v = {{56{~u & r[7]}},  r[7:0]};
      2'd1:    v = {{48{~u & r[15]}}, r[15:0]};
      2'd2:    v = {{32{~u & r[31]}}, r[31:0]};
      default: v = r;
    endcase
    return v;
  endfunction

  // FSM and latched command
  state_t                 state_q,  state_d;
  logic [2:0]             beat_q,   beat_d;
  logic                   last_q,   last_d;    // port granted most recently
  logic                   owner_q,  owner_d;   // port being serviced
  logic                   we_q,     we_d;
  logic [addr_size-1:0]   addr_q,   addr_d;
  logic [1:0]             size_q,   size_d;
  logic                   uns_q,    uns_d;
  logic [data_length-1:0] wdata_q,  wdata_d;
  logic [data_length-1:0] result_q, result_d;

  // Registered outputs
  logic                   gnt0_q,      gnt0_d;
  logic                   gnt1_q,      gnt1_d;
  logic                   done0_q,     done0_d;
  logic                   done1_q,     done1_d;
  logic [data_length-1:0] rdata0_q,    rdata0_d;
  logic [data_length-1:0] rdata1_q,    rdata1_d;
  logic                   mem_read_q,  mem_read_d;
  logic                   mem_write_q, mem_write_d;
  logic [addr_size-1:0]   mem_addr_q,  mem_addr_d;
  logic [7:0]             mem_wdata_q, mem_wdata_d;

  // Arbitration: a lone requester wins; on a tie the port not granted last.
  logic any_req;
  logic sel_port;

  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    any_req  = bus.req0 | bus.req1;
    sel_port = 1'b0;
    if (bus.req0 && bus.req1) begin
      sel_port = ~last_q;
    end else if (bus.req1) begin
      sel_port = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order; the async reset
    // clears all of them immediately, which also drops mem_write mid-access.
    if (reset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      result_q    <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      result_q    <= result_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state: arbitration, command latch, beat sequencing, load assembly
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    last_d   = last_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    size_d   = size_q;
    uns_d    = uns_q;
    wdata_d  = wdata_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = XFER;
          beat_d   = '0;
          last_d   = sel_port;
          owner_d  = sel_port;
          we_d     = sel_port ? bus.we1    : bus.we0;
          addr_d   = sel_port ? bus.addr1  : bus.addr0;
          size_d   = sel_port ? bus.size1  : bus.size0;
          uns_d    = sel_port ? bus.uns1   : bus.uns0;
          wdata_d  = sel_port ? bus.wdata1 : bus.wdata0;
          result_d = '0;
        end
      end

      XFER: begin
        // The load byte for this beat is on mem_rdata now; capture it at the edge.
        if (!we_q) begin
          result_d[{beat_q, 3'b000} +: 8] = bus.mem_rdata;
        end
        if (beat_q == last_beat(size_q)) begin
          state_d = DONE;
        end else begin
          beat_d = beat_q + 3'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
        beat_d  = '0;
      end

      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: the values each output flop takes for the coming cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;

    // Grant pulse coincides with the first beat.
    if (state_q == IDLE && state_d == XFER) begin
      gnt0_d = ~owner_d;
      gnt1_d =  owner_d;
    end

    // Beat k drives address base+k (wrapping) and, for stores, byte k.
    if (state_d == XFER) begin
      mem_read_d  = ~we_d;
      mem_write_d =  we_d;
      mem_addr_d  = addr_d + addr_size'(beat_d);
      if (we_d) begin
        mem_wdata_d = wdata_d[{beat_d, 3'b000} +: 8];
      end
    end

    // Completion: extend using result_d, which already holds the final byte.
    if (state_d == DONE) begin
      done0_d = ~owner_q;
      done1_d =  owner_q;
      if (!we_q) begin
        if (owner_q) begin
          rdata1_d = extend(result_d, size_q, uns_q);
        end else begin
          rdata0_d = extend(result_d, size_q, uns_q);
        end
      end
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
// Directed bench for dmem_port_arbiter: a 256-byte memory model (indexed by
// the low address byte) answers the memory port, and each step checks the
// handshake, beat addresses/data and the extended load results against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic clk;
  logic reset;

  dmem_port_arbiter_if #(.addr_size(AW), .data_length(DW)) bus ();

  dmem_port_arbiter #(.addr_size(AW), .data_length(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: byte 12 = 0xAA, bytes 5..8 = 00 00 00 80, everything else 0xFF.
  initial begin : mem_model
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    mem[12] = 8'hAA;
    mem[5]  = 8'h00;
    mem[6]  = 8'h00;
    mem[7]  = 8'h00;
    mem[8]  = 8'h80;
    forever begin
      @(posedge clk);
      if (bus.mem_write) mem[bus.mem_addr[7:0]] = bus.mem_wdata;
    end
  end

  always_comb bus.mem_rdata = mem[bus.mem_addr[7:0]];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE and follow it through every beat; returns in
  // the DONE cycle. The port inputs are scrambled after grant to show the
  // command was latched.
  task automatic access(input bit port, input bit we, input logic [63:0] addr,
                        input logic [1:0] size, input bit uns,
                        input logic [63:0] wdata, input string tag);
    int n;
    n = 1 << size;
    if (port) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr;
      bus.size1 = size; bus.uns1 = uns; bus.wdata1 = wdata;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr;
      bus.size0 = size; bus.uns0 = uns; bus.wdata0 = wdata;
    end
    step();
    check({tag, " gnt"}, {bus.gnt1, bus.gnt0}, port ? 2'b10 : 2'b01);
    if (port) begin
      bus.req1 = 1'b0; bus.we1 = ~we; bus.addr1 = ~addr;
      bus.size1 = ~size; bus.uns1 = ~uns; bus.wdata1 = ~wdata;
    end else begin
      bus.req0 = 1'b0; bus.we0 = ~we; bus.addr0 = ~addr;
      bus.size0 = ~size; bus.uns0 = ~uns; bus.wdata0 = ~wdata;
    end
    for (int k = 0; k < n; k++) begin
      if (k != 0) begin
        step();
        check({tag, " gnt clear"}, {bus.gnt1, bus.gnt0}, 2'b00);
      end
      check({tag, " addr"}, bus.mem_addr, addr + 64'(k));
      check({tag, " rd/wr"}, {bus.mem_read, bus.mem_write}, we ? 2'b01 : 2'b10);
      if (we) check({tag, " wdata"}, bus.mem_wdata, wdata[8*k +: 8]);
      check({tag, " done early"}, {bus.done1, bus.done0}, 2'b00);
    end
    step();
    check({tag, " done"}, {bus.done1, bus.done0}, port ? 2'b10 : 2'b01);
    check({tag, " done rd/wr"}, {bus.mem_read, bus.mem_write}, 2'b00);
  endtask

  initial begin : stimulus
    int         ngnt;
    logic [3:0] order;

    reset = 1'b0;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.size0 = '0; bus.uns0 = 1'b0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.size1 = '0; bus.uns1 = 1'b0; bus.wdata1 = '0;

    // Reset state
    #2 reset = 1'b1;
    #1;
    check("rst gnt",       {bus.gnt1, bus.gnt0},   2'b00);
    check("rst done",      {bus.done1, bus.done0}, 2'b00);
    check("rst rdata0",    bus.rdata0,    64'h0);
    check("rst rdata1",    bus.rdata1,    64'h0);
    check("rst mem rd/wr", {bus.mem_read, bus.mem_write}, 2'b00);
    check("rst mem_addr",  bus.mem_addr,  64'h0);
    check("rst mem_wdata", bus.mem_wdata, 64'h0);
    step();
    step();
    reset = 1'b0;

    // Both ports requesting continuously: grants 0,1,0,1 every 3 cycles.
    bus.req0 = 1'b1; bus.addr0 = 64'd12; bus.uns0 = 1'b0;
    bus.req1 = 1'b1; bus.addr1 = 64'd40; bus.uns1 = 1'b1;
    ngnt  = 0;
    order = 4'b0000;
    for (int c = 1; c <= 12; c++) begin
      step();
      check("rr exclusive",
            {(bus.gnt0 & bus.gnt1), (bus.done0 & bus.done1), (bus.mem_read & bus.mem_write)}, 3'b000);
      if (bus.gnt0 | bus.gnt1) begin
        if (ngnt < 4) order[ngnt] = bus.gnt1;
        ngnt++;
      end
      if (c == 10) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
    end
    check("rr grant count", 64'(ngnt), 64'd4);
    check("rr grant order", order, 4'b1010);
    check("rr rdata0", bus.rdata0, 64'hFFFF_FFFF_FFFF_FFAA);
    check("rr rdata1", bus.rdata1, 64'h0000_0000_0000_00FF);

    // Byte loads at 12, zero- then sign-extended.
    access(1'b0, 1'b0, 64'd12, 2'd0, 1'b1, 64'h0, "ld_b_u");
    check("ld_b_u rdata0", bus.rdata0, 64'h0000_0000_0000_00AA);
    step();
    access(1'b0, 1'b0, 64'd12, 2'd0, 1'b0, 64'h0, "ld_b_s");
    check("ld_b_s rdata0", bus.rdata0, 64'hFFFF_FFFF_FFFF_FFAA);
    step();
    check("idle after done", {bus.done1, bus.done0}, 2'b00);
    check("rdata0 held", bus.rdata0, 64'hFFFF_FFFF_FFFF_FFAA);

    // Double store from port 1, then double load back from port 0.
    access(1'b1, 1'b1, 64'd40, 2'd3, 1'b0, 64'h0807_0605_0403_0201, "st_d");
    check("st_d rdata1 kept", bus.rdata1, 64'h0000_0000_0000_00FF);
    step();
    check("st_d mem40", mem[40], 8'h01);
    check("st_d mem47", mem[47], 8'h08);
    access(1'b0, 1'b0, 64'd40, 2'd3, 1'b1, 64'h0, "ld_d");
    check("ld_d rdata0", bus.rdata0, 64'h0807_0605_0403_0201);
    step();

    // Half store wrapping from the top of the address space to 0.
    access(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 1'b0, 64'h1234, "st_h_wrap");
    step();
    check("st_h_wrap mem top", mem[255], 8'h34);
    check("st_h_wrap mem 0",   mem[0],   8'h12);

    // Misaligned word load, sign-extended.
    access(1'b1, 1'b0, 64'd5, 2'd2, 1'b0, 64'h0, "ld_w_s");
    check("ld_w_s rdata1", bus.rdata1, 64'hFFFF_FFFF_8000_0000);
    step();

    // Reset during beat 3 of an 8-byte store at 100.
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 64'd100;
    bus.size1 = 2'd3; bus.uns1 = 1'b0; bus.wdata1 = 64'hA7A6_A5A4_A3A2_A1A0;
    step();
    check("rst_st gnt1", bus.gnt1, 1'b1);
    bus.req1 = 1'b0;
    step();
    step();
    step();
    check("rst_st beat3 addr", bus.mem_addr, 64'd103);
    check("rst_st beat3 write", bus.mem_write, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rst_st mem rd/wr", {bus.mem_read, bus.mem_write}, 2'b00);
    check("rst_st mem_addr",  bus.mem_addr,  64'h0);
    check("rst_st mem_wdata", bus.mem_wdata, 64'h0);
    check("rst_st rdata1",    bus.rdata1,    64'h0);
    check("rst_st rdata0",    bus.rdata0,    64'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_st no done", {bus.done1, bus.done0}, 2'b00);
    end
    reset = 1'b0;
    check("rst_st mem100", mem[100], 8'hA0);
    check("rst_st mem102", mem[102], 8'hA2);
    check("rst_st mem103", mem[103], 8'hFF);
    check("rst_st mem107", mem[107], 8'hFF);

    // First request after reset is serviced normally.
    access(1'b0, 1'b0, 64'd100, 2'd0, 1'b1, 64'h0, "post_rst");
    check("post_rst rdata0", bus.rdata0, 64'h0000_0000_0000_00A0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
